// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared encodings and constants for the PC sequencer
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_WAIT = 2'b10,
        ST_HALT = 2'b11
    } state_e;

    localparam logic [31:0] START_ADDR_DEFAULT = 32'h0001_0000;
    localparam logic [31:0] INSTR_BYTES        = 32'd4;

    // Which rule decided the next pc this cycle, highest priority first.
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_HALT,
        SEL_EX,
        SEL_ID,
        SEL_STALL,
        SEL_WAIT,
        SEL_SEQ
    } sel_e;

    // Fetch addresses are word aligned; redirect targets drop their low bits.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch-control bus between pipeline and PC sequencer (optional PC_SEQ_PERF_EN counters)
interface pc_sequencer_if
`ifdef PC_SEQ_PERF_EN
    #(parameter int PERF_W = 32)
`endif
    ;

    logic        stall_d;
    logic        ex_redir;
    logic [31:0] ex_target;
    logic        id_redir;
    logic [31:0] id_target;
    logic        imem_ready;
    logic        halt_req;
    logic        fetch_valid;
    logic [31:0] pc;
    logic [31:0] pc_d;
    logic        flush_d;
    logic        flush_e;
    logic        misalign;
    logic [1:0]  state;

`ifdef PC_SEQ_PERF_EN
    logic [PERF_W-1:0] perf_stall_cnt;
    logic [PERF_W-1:0] perf_redir_cnt;
    logic [PERF_W-1:0] perf_wait_cnt;

    modport master (
        output stall_d, ex_redir, ex_target, id_redir, id_target, imem_ready, halt_req,
        input  fetch_valid, pc, pc_d, flush_d, flush_e, misalign, state,
        input  perf_stall_cnt, perf_redir_cnt, perf_wait_cnt
    );

    modport slave (
        input  stall_d, ex_redir, ex_target, id_redir, id_target, imem_ready, halt_req,
        output fetch_valid, pc, pc_d, flush_d, flush_e, misalign, state,
        output perf_stall_cnt, perf_redir_cnt, perf_wait_cnt
    );
`else
    modport master (
        output stall_d, ex_redir, ex_target, id_redir, id_target, imem_ready, halt_req,
        input  fetch_valid, pc, pc_d, flush_d, flush_e, misalign, state
    );

    modport slave (
        input  stall_d, ex_redir, ex_target, id_redir, id_target, imem_ready, halt_req,
        output fetch_valid, pc, pc_d, flush_d, flush_e, misalign, state
    );
`endif

endinterface

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational priority select of the next fetch address
module pc_next_sel
    import pc_sequencer_pkg::*;
(
    input  logic        active,
    input  logic        halt_req,
    input  logic        ex_redir,
    input  logic [31:0] ex_target,
    input  logic        id_redir,
    input  logic [31:0] id_target,
    input  logic        stall_d,
    input  logic        imem_ready,
    input  logic [31:0] pc,
    output sel_e        sel,
    output logic [31:0] next_pc,
    output logic        flush_d,
    output logic        flush_e,
    output logic        misalign_hit
);

    // Halt beats redirects; the older EX redirect beats the ID one; redirects beat holds.
    always_comb begin
        sel          = SEL_NONE;
        next_pc      = pc;
        flush_d      = 1'b0;
        flush_e      = 1'b0;
        misalign_hit = 1'b0;
        if (active) begin
            if (halt_req) begin
                sel = SEL_HALT;
            end else if (ex_redir) begin
                sel          = SEL_EX;
                next_pc      = align_word(ex_target);
                flush_d      = 1'b1;
                flush_e      = 1'b1;
                misalign_hit = (ex_target[1:0] != 2'b00);
            end else if (id_redir) begin
                sel          = SEL_ID;
                next_pc      = align_word(id_target);
                flush_d      = 1'b1;
                misalign_hit = (id_target[1:0] != 2'b00);
            end else if (stall_d) begin
                sel = SEL_STALL;
            end else if (!imem_ready) begin
                sel = SEL_WAIT;
            end else begin
                sel     = SEL_SEQ;
                next_pc = pc + INSTR_BYTES;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC owner and redirect/flush controller (optional PC_SEQ_PERF_EN counters)
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] START_ADDR = START_ADDR_DEFAULT
`ifdef PC_SEQ_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_sequencer_if.slave        bus
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] dpc_q, dpc_d;
    logic        misalign_q, misalign_d;
    logic        fetch_valid_q, fetch_valid_d;

    logic        active;
    sel_e        sel;
    logic [31:0] next_pc;
    logic        sel_flush_d;
    logic        sel_flush_e;
    logic        misalign_hit;

    assign active = (state_q == ST_RUN) || (state_q == ST_WAIT);

    pc_next_sel u_next_sel (
        .active       (active),
        .halt_req     (bus.halt_req),
        .ex_redir     (bus.ex_redir),
        .ex_target    (bus.ex_target),
        .id_redir     (bus.id_redir),
        .id_target    (bus.id_target),
        .stall_d      (bus.stall_d),
        .imem_ready   (bus.imem_ready),
        .pc           (pc_q),
        .sel          (sel),
        .next_pc      (next_pc),
        .flush_d      (sel_flush_d),
        .flush_e      (sel_flush_e),
        .misalign_hit (misalign_hit)
    );

    // Next state, fetch pc and decode pc from the selected rule.
    always_comb begin
        state_d    = state_q;
        pc_d       = next_pc;
        dpc_d      = dpc_q;
        misalign_d = misalign_q | misalign_hit;
        case (sel)
            SEL_NONE:         if (state_q == ST_BOOT) state_d = ST_RUN;
            SEL_HALT:         state_d = ST_HALT;
            SEL_EX, SEL_ID:   state_d = ST_RUN;
            SEL_STALL:        state_d = state_q;
            SEL_WAIT:         state_d = ST_WAIT;
            SEL_SEQ: begin
                state_d = ST_RUN;
                dpc_d   = pc_q;
            end
            default:          state_d = state_q;
        endcase
        fetch_valid_d = (state_d == ST_RUN) || (state_d == ST_WAIT);
    end

    // FSM and fetch registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= START_ADDR;
            dpc_q         <= START_ADDR;
            misalign_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            dpc_q         <= dpc_d;
            misalign_q    <= misalign_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    assign bus.fetch_valid = fetch_valid_q;
    assign bus.pc          = pc_q;
    assign bus.pc_d        = dpc_q;
    assign bus.flush_d     = sel_flush_d;
    assign bus.flush_e     = sel_flush_e;
    assign bus.misalign    = misalign_q;
    assign bus.state       = state_q;

`ifdef PC_SEQ_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] redir_cnt_q, redir_cnt_d;
    logic [PERF_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              is_redir;

    assign is_redir = (sel == SEL_EX) || (sel == SEL_ID);

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if ((sel == SEL_STALL) && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
        if (is_redir && !(&redir_cnt_q))           redir_cnt_d = redir_cnt_q + PERF_W'(1);
        if ((state_q == ST_WAIT) && !is_redir && !(&wait_cnt_q))
            wait_cnt_d = wait_cnt_q + PERF_W'(1);
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign bus.perf_stall_cnt = stall_cnt_q;
    assign bus.perf_redir_cnt = redir_cnt_q;
    assign bus.perf_wait_cnt  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer (PC_SEQ_PERF_EN aware)
module tb_pc_sequencer;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    pc_sequencer_if bus_if ();

    pc_sequencer #(.START_ADDR(32'h0001_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: spec state numbers, fetch pc, decode pc, sticky flag.
    int          m_st;
    logic [31:0] m_pc;
    logic [31:0] m_pcd;
    logic        m_mis;
    logic        exp_fd, exp_fe, obs_fd, obs_fe;
`ifdef PC_SEQ_PERF_EN
    logic [31:0] m_pstall, m_predir, m_pwait;
`endif

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (&v) return v;
        return v + 32'd1;
    endfunction

    task automatic model_reset();
        m_st  = 0;
        m_pc  = 32'h0001_0000;
        m_pcd = 32'h0001_0000;
        m_mis = 1'b0;
`ifdef PC_SEQ_PERF_EN
        m_pstall = 0; m_predir = 0; m_pwait = 0;
`endif
    endtask

    task automatic model_edge();
        bit fetching = (m_st == 1) || (m_st == 2);
        bit halt  = bus_if.halt_req;
        bit ex    = bus_if.ex_redir;
        bit id    = bus_if.id_redir;
        bit stall = bus_if.stall_d;
        bit rdy   = bus_if.imem_ready;
        if (m_st == 0) begin
            m_st = 1;
        end else if (fetching) begin
`ifdef PC_SEQ_PERF_EN
            if (m_st == 2 && !(!halt && (ex || id))) m_pwait = sat_inc(m_pwait);
            if (!halt && (ex || id)) m_predir = sat_inc(m_predir);
            if (!halt && !ex && !id && stall) m_pstall = sat_inc(m_pstall);
`endif
            if (halt) begin
                m_st = 3;
            end else if (ex) begin
                m_pc  = bus_if.ex_target & 32'hFFFF_FFFC;
                if (bus_if.ex_target[1:0] != 0) m_mis = 1'b1;
                m_st  = 1;
            end else if (id) begin
                m_pc  = bus_if.id_target & 32'hFFFF_FFFC;
                if (bus_if.id_target[1:0] != 0) m_mis = 1'b1;
                m_st  = 1;
            end else if (stall) begin
                m_st = m_st;
            end else if (!rdy) begin
                m_st = 2;
            end else begin
                m_pcd = m_pc;
                m_pc  = m_pc + 32'd4;
                m_st  = 1;
            end
        end
    endtask

    // One clock: predict flushes, sample them mid-cycle, advance the model, settle after the edge.
    task automatic tick();
        bit fetching = (m_st == 1) || (m_st == 2);
        exp_fd = fetching && !bus_if.halt_req && (bus_if.ex_redir || bus_if.id_redir);
        exp_fe = fetching && !bus_if.halt_req && bus_if.ex_redir;
        @(negedge clk);
        obs_fd = bus_if.flush_d;
        obs_fe = bus_if.flush_e;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.stall_d    = 1'b0;
        bus_if.ex_redir   = 1'b0;
        bus_if.ex_target  = 32'h0;
        bus_if.id_redir   = 1'b0;
        bus_if.id_target  = 32'h0;
        bus_if.imem_ready = 1'b1;
        bus_if.halt_req   = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (bus_if.state !== 2'b00) $display("FAIL reset_state: got %0d need 0", bus_if.state); else n_pass++;
        n_total++; if (bus_if.pc !== 32'h0001_0000) $display("FAIL reset_pc: got %h need 00010000", bus_if.pc); else n_pass++;
        n_total++; if (bus_if.pc_d !== 32'h0001_0000) $display("FAIL reset_pc_d: got %h need 00010000", bus_if.pc_d); else n_pass++;
        n_total++; if (bus_if.misalign !== 1'b0) $display("FAIL reset_misalign: got %b need 0", bus_if.misalign); else n_pass++;
        n_total++; if (bus_if.fetch_valid !== 1'b0) $display("FAIL reset_fetch_valid: got %b need 0", bus_if.fetch_valid); else n_pass++;
        n_total++; if ({bus_if.flush_d, bus_if.flush_e} !== 2'b00) $display("FAIL reset_flush: got %b need 00", {bus_if.flush_d, bus_if.flush_e}); else n_pass++;
    endtask

    task automatic test_boot_advance();
        rst_n = 1'b1;
        #1;
        n_total++; if (bus_if.fetch_valid !== 1'b0) $display("FAIL boot_fetch_valid: got %b need 0", bus_if.fetch_valid); else n_pass++;
        tick();
        n_total++; if (bus_if.state !== 2'b01) $display("FAIL boot_to_run: got %0d need 1", bus_if.state); else n_pass++;
        n_total++; if (bus_if.fetch_valid !== 1'b1) $display("FAIL run_fetch_valid: got %b need 1", bus_if.fetch_valid); else n_pass++;
        n_total++; if (bus_if.pc !== 32'h0001_0000) $display("FAIL boot_pc_hold: got %h need 00010000", bus_if.pc); else n_pass++;
        tick();
        n_total++; if (bus_if.pc !== 32'h0001_0004) $display("FAIL adv1_pc: got %h need 00010004", bus_if.pc); else n_pass++;
        n_total++; if (bus_if.pc_d !== 32'h0001_0000) $display("FAIL adv1_pc_d: got %h need 00010000", bus_if.pc_d); else n_pass++;
        tick();
        n_total++; if (bus_if.pc !== 32'h0001_0008) $display("FAIL adv2_pc: got %h need 00010008", bus_if.pc); else n_pass++;
        n_total++; if (bus_if.pc_d !== 32'h0001_0004) $display("FAIL adv2_pc_d: got %h need 00010004", bus_if.pc_d); else n_pass++;
        n_total++; if ({obs_fd, obs_fe} !== 2'b00) $display("FAIL adv_flush: got %b need 00", {obs_fd, obs_fe}); else n_pass++;
    endtask

    task automatic test_redirect_priority();
        bus_if.ex_redir = 1'b1; bus_if.ex_target = 32'h0002_0000;
        bus_if.id_redir = 1'b1; bus_if.id_target = 32'h0003_0000;
        tick();
        clear_inputs();
        n_total++; if ({obs_fd, obs_fe} !== 2'b11) $display("FAIL prio_flush: got %b need 11", {obs_fd, obs_fe}); else n_pass++;
        n_total++; if (bus_if.pc !== 32'h0002_0000) $display("FAIL prio_pc: got %h need 00020000", bus_if.pc); else n_pass++;
        n_total++; if (bus_if.state !== 2'b01) $display("FAIL prio_state: got %0d need 1", bus_if.state); else n_pass++;
    endtask

    task automatic test_stall_wait();
        bus_if.stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_if.imem_ready = (i == 2);
            tick();
            n_total++; if (bus_if.pc !== 32'h0002_0000 || bus_if.pc_d !== 32'h0001_0004)
                $display("FAIL stall_hold_%0d: got pc %h pc_d %h need 00020000 00010004", i, bus_if.pc, bus_if.pc_d); else n_pass++;
            n_total++; if (bus_if.state !== 2'b01) $display("FAIL stall_state_%0d: got %0d need 1", i, bus_if.state); else n_pass++;
        end
        bus_if.stall_d = 1'b0; bus_if.imem_ready = 1'b0;
        tick();
        n_total++; if (bus_if.state !== 2'b10) $display("FAIL wait_enter: got %0d need 2", bus_if.state); else n_pass++;
        n_total++; if (bus_if.fetch_valid !== 1'b1) $display("FAIL wait_fetch_valid: got %b need 1", bus_if.fetch_valid); else n_pass++;
        bus_if.imem_ready = 1'b1;
        tick();
        n_total++; if (bus_if.state !== 2'b01) $display("FAIL wait_exit: got %0d need 1", bus_if.state); else n_pass++;
        n_total++; if (bus_if.pc !== 32'h0002_0004 || bus_if.pc_d !== 32'h0002_0000)
            $display("FAIL wait_adv: got pc %h pc_d %h need 00020004 00020000", bus_if.pc, bus_if.pc_d); else n_pass++;
    endtask

    task automatic test_misalign();
        bus_if.id_redir = 1'b1; bus_if.id_target = 32'h0001_0006;
        tick();
        clear_inputs();
        n_total++; if ({obs_fd, obs_fe} !== 2'b10) $display("FAIL id_flush: got %b need 10", {obs_fd, obs_fe}); else n_pass++;
        n_total++; if (bus_if.pc !== 32'h0001_0004) $display("FAIL misalign_pc: got %h need 00010004", bus_if.pc); else n_pass++;
        n_total++; if (bus_if.misalign !== 1'b1) $display("FAIL misalign_set: got %b need 1", bus_if.misalign); else n_pass++;
        bus_if.ex_redir = 1'b1; bus_if.ex_target = 32'h0003_0000;
        tick();
        clear_inputs();
        n_total++; if (bus_if.misalign !== 1'b1) $display("FAIL misalign_sticky: got %b need 1", bus_if.misalign); else n_pass++;
        n_total++; if (bus_if.pc !== 32'h0003_0000) $display("FAIL aligned_redir_pc: got %h need 00030000", bus_if.pc); else n_pass++;
    endtask

    task automatic test_wrap();
        bus_if.ex_redir = 1'b1; bus_if.ex_target = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        n_total++; if (bus_if.pc !== 32'hFFFF_FFFC) $display("FAIL wrap_load: got %h need fffffffc", bus_if.pc); else n_pass++;
        tick();
        n_total++; if (bus_if.pc !== 32'h0000_0000) $display("FAIL wrap_pc: got %h need 00000000", bus_if.pc); else n_pass++;
        n_total++; if (bus_if.pc_d !== 32'hFFFF_FFFC) $display("FAIL wrap_pc_d: got %h need fffffffc", bus_if.pc_d); else n_pass++;
    endtask

    task automatic test_halt_reset();
        bus_if.halt_req = 1'b1; bus_if.ex_redir = 1'b1; bus_if.ex_target = 32'h0004_0000;
        tick();
        n_total++; if ({obs_fd, obs_fe} !== 2'b00) $display("FAIL halt_flush: got %b need 00", {obs_fd, obs_fe}); else n_pass++;
        n_total++; if (bus_if.state !== 2'b11) $display("FAIL halt_state: got %0d need 3", bus_if.state); else n_pass++;
        n_total++; if (bus_if.fetch_valid !== 1'b0) $display("FAIL halt_fetch_valid: got %b need 0", bus_if.fetch_valid); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            bus_if.ex_redir = 1'($urandom); bus_if.id_redir = 1'($urandom);
            bus_if.ex_target = $urandom; bus_if.id_target = $urandom;
            bus_if.halt_req = 1'($urandom); bus_if.stall_d = 1'($urandom);
            tick();
            n_total++; if (bus_if.pc !== 32'h0 || bus_if.state !== 2'b11 || {obs_fd, obs_fe} !== 2'b00)
                $display("FAIL halt_frozen_%0d: got pc %h state %0d flush %b need 00000000 3 00", i, bus_if.pc, bus_if.state, {obs_fd, obs_fe}); else n_pass++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_total++; if (bus_if.pc !== 32'h0001_0000) $display("FAIL async_reset_pc: got %h need 00010000", bus_if.pc); else n_pass++;
        n_total++; if (bus_if.state !== 2'b00) $display("FAIL async_reset_state: got %0d need 0", bus_if.state); else n_pass++;
        n_total++; if (bus_if.misalign !== 1'b0) $display("FAIL misalign_cleared: got %b need 0", bus_if.misalign); else n_pass++;
`ifdef PC_SEQ_PERF_EN
        n_total++; if ({bus_if.perf_stall_cnt, bus_if.perf_redir_cnt, bus_if.perf_wait_cnt} !== '0)
            $display("FAIL perf_reset: got %0d %0d %0d need 0 0 0", bus_if.perf_stall_cnt, bus_if.perf_redir_cnt, bus_if.perf_wait_cnt); else n_pass++;
`endif
        clear_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(59) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                n_total++; if (bus_if.pc !== m_pc || bus_if.state !== 2'b00)
                    $display("FAIL rnd_reset_%0d: got pc %h state %0d need %h 0", i, bus_if.pc, bus_if.state, m_pc); else n_pass++;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end else begin
                logic [31:0] t;
                bus_if.halt_req   = ($urandom_range(39) == 0);
                bus_if.ex_redir   = ($urandom_range(5) == 0);
                bus_if.id_redir   = ($urandom_range(4) == 0);
                bus_if.stall_d    = ($urandom_range(3) == 0);
                bus_if.imem_ready = ($urandom_range(3) != 0);
                t = $urandom; if ($urandom_range(3) != 0) t[1:0] = 2'b00;
                bus_if.ex_target = t;
                t = $urandom; if ($urandom_range(3) != 0) t[1:0] = 2'b00;
                bus_if.id_target = t;
                tick();
                n_total++; if ({obs_fd, obs_fe} !== {exp_fd, exp_fe})
                    $display("FAIL rnd_flush_%0d: got %b need %b", i, {obs_fd, obs_fe}, {exp_fd, exp_fe}); else n_pass++;
                n_total++; if (bus_if.state !== 2'(m_st) || bus_if.fetch_valid !== (m_st == 1 || m_st == 2))
                    $display("FAIL rnd_state_%0d: got %0d/%b need %0d", i, bus_if.state, bus_if.fetch_valid, m_st); else n_pass++;
                n_total++; if (bus_if.pc !== m_pc || bus_if.pc_d !== m_pcd)
                    $display("FAIL rnd_pc_%0d: got %h %h need %h %h", i, bus_if.pc, bus_if.pc_d, m_pc, m_pcd); else n_pass++;
                n_total++; if (bus_if.misalign !== m_mis)
                    $display("FAIL rnd_misalign_%0d: got %b need %b", i, bus_if.misalign, m_mis); else n_pass++;
`ifdef PC_SEQ_PERF_EN
                n_total++; if (bus_if.perf_stall_cnt !== m_pstall || bus_if.perf_redir_cnt !== m_predir || bus_if.perf_wait_cnt !== m_pwait)
                    $display("FAIL rnd_perf_%0d: got %0d %0d %0d need %0d %0d %0d", i, bus_if.perf_stall_cnt,
                             bus_if.perf_redir_cnt, bus_if.perf_wait_cnt, m_pstall, m_predir, m_pwait); else n_pass++;
`endif
            end
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_boot_advance();
        test_redirect_priority();
        test_stall_wait();
        test_misalign();
        test_wrap();
        test_halt_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
